// File: rtl/dm_handshake.sv
// Byte-addressed data memory with a valid/ready request port and a registered response.
// Sized loads/stores over four byte-lane banks; word-crossing accesses take two beats.
// A zeroing sweep runs after reset, and every modified word is echoed on a debug port.
module dm_handshake #(
  parameter int unsigned ADDRESS_WIDTH    = 10,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_address,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        debug_valid,
  output logic [31:0] debug_address,
  output logic [31:0] debug_word,
  output logic        clear_done
);

  localparam int unsigned WordBits = ADDRESS_WIDTH - 2;
  localparam int unsigned Depth    = 1 << WordBits;

  typedef enum logic [1:0] {StClear, StIdle, StSplit} state_e;

  state_e r_state, w_state_next;

  logic [7:0] r_mem [4][Depth];

  logic [WordBits-1:0]      r_idx;
  logic                     r_write;
  logic [2:0]               r_size;
  logic                     r_signed;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [31:0]              r_wdata;
  logic [31:0]              r_raw;
  logic                     r_resp_valid;
  logic                     r_resp_error;
  logic [31:0]              r_resp_rdata;
  logic                     r_dbg_valid;
  logic [31:0]              r_dbg_addr;
  logic [31:0]              r_dbg_word;
  logic                     r_clear_done;

  logic                     w_split;
  logic [ADDRESS_WIDTH-1:0] w_addr;
  logic [2:0]               w_size;
  logic                     w_write;
  logic                     w_signed;
  logic [31:0]              w_wdata;
  logic [1:0]               w_off;
  logic [WordBits-1:0]      w_widx;
  logic                     w_size_ok;
  logic                     w_cross;
  logic                     w_accept;
  logic                     w_acc_err;
  logic                     w_acc_ok;
  logic                     w_beat;
  logic [3:0][1:0]          w_lane_k;
  logic [3:0]               w_lane_act;
  logic [3:0][7:0]          w_rd_byte;
  logic [3:0][7:0]          w_merged;
  logic [31:0]              w_raw_beat;
  logic [31:0]              w_raw_full;
  logic [3:0]               w_mem_we;
  logic [WordBits-1:0]      w_mem_idx;
  logic [3:0][7:0]          w_mem_byte;
  logic                     w_unused_addr;

  assign w_unused_addr = ^req_address[31:ADDRESS_WIDTH];

  function automatic logic [31:0] f_extend(input logic [31:0] raw, input logic [2:0] size,
                                           input logic sgn);
    case (size)
      3'd1:    return {{24{sgn & raw[7]}}, raw[7:0]};
      3'd2:    return {{16{sgn & raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  // Select the live request: the port in IDLE, the captured request during the second beat.
  always_comb begin
    w_split   = (r_state == StSplit);
    w_addr    = w_split ? r_addr   : req_address[ADDRESS_WIDTH-1:0];
    w_size    = w_split ? r_size   : req_size;
    w_write   = w_split ? r_write  : req_write;
    w_signed  = w_split ? r_signed : req_signed;
    w_wdata   = w_split ? r_wdata  : req_wdata;
    w_off     = w_addr[1:0];
    // Second beat addresses the following word; wraps at the top of memory.
    w_widx    = w_addr[ADDRESS_WIDTH-1:2] + (w_split ? WordBits'(1) : WordBits'(0));
    w_size_ok = (req_size == 3'd1) || (req_size == 3'd2) || (req_size == 3'd4);
    w_cross   = ({2'b00, w_off} + {1'b0, w_size}) > 4'd4;
    w_accept  = req_valid && req_ready;
    w_acc_err = w_accept && (!w_size_ok || (w_cross && !ALLOW_MISALIGNED));
    w_acc_ok  = w_accept && !w_acc_err;
    w_beat    = w_acc_ok || w_split;
  end

  // Lane L carries access byte k = L - offset; lanes below the offset belong to the next word.
  always_comb begin
    w_lane_k   = '0;
    w_lane_act = '0;
    for (int l = 0; l < 4; l++) begin
      w_lane_k[l]   = 2'(l) - w_off;
      w_lane_act[l] = w_beat && ({1'b0, w_lane_k[l]} < w_size) && ((2'(l) < w_off) == w_split);
    end
  end

  // Read the addressed word, merge store bytes and gather load bytes into access order.
  always_comb begin
    w_rd_byte  = '0;
    w_merged   = '0;
    w_raw_beat = '0;
    for (int l = 0; l < 4; l++) begin
      w_rd_byte[l] = r_mem[l][w_widx];
      w_merged[l]  = (w_lane_act[l] && w_write) ? w_wdata[{w_lane_k[l], 3'b000} +: 8]
                                                 : w_rd_byte[l];
      if (w_lane_act[l] && !w_write) begin
        w_raw_beat[{w_lane_k[l], 3'b000} +: 8] = w_rd_byte[l];
      end
    end
    w_raw_full = (w_split ? r_raw : 32'h0) | w_raw_beat;
  end

  // Memory write port: the sweep zeroes whole words, otherwise only active store lanes.
  always_comb begin
    if (r_state == StClear) begin
      w_mem_we   = 4'hF;
      w_mem_idx  = r_idx;
      w_mem_byte = '0;
    end else begin
      w_mem_we   = w_lane_act & {4{w_write}};
      w_mem_idx  = w_widx;
      w_mem_byte = w_merged;
    end
  end

  // Byte-lane banks; contents are not reset, the sweep clears them.
  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (w_mem_we[l]) r_mem[l][w_mem_idx] <= w_mem_byte[l];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= StClear;
    else        r_state <= w_state_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StClear: if (&r_idx) w_state_next = StIdle;
      StIdle:  if (w_acc_ok && w_cross) w_state_next = StSplit;
      StSplit: w_state_next = StIdle;
      default: w_state_next = StClear;
    endcase
  end

  // FSM outputs.
  always_comb begin
    req_ready = (r_state == StIdle);
  end

  // Sweep counter, captured request, response and debug registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx        <= '0;
      r_write      <= 1'b0;
      r_size       <= '0;
      r_signed     <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_raw        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_error <= 1'b0;
      r_resp_rdata <= '0;
      r_dbg_valid  <= 1'b0;
      r_dbg_addr   <= '0;
      r_dbg_word   <= '0;
      r_clear_done <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_error <= 1'b0;
      r_resp_rdata <= '0;
      r_dbg_valid  <= 1'b0;
      if (r_state == StClear) begin
        r_idx <= r_idx + WordBits'(1);
        if (&r_idx) r_clear_done <= 1'b1;
      end
      if (w_accept) begin
        r_write  <= req_write;
        r_size   <= req_size;
        r_signed <= req_signed;
        r_addr   <= req_address[ADDRESS_WIDTH-1:0];
        r_wdata  <= req_wdata;
        r_raw    <= w_raw_beat;
      end
      if (w_acc_err) begin
        r_resp_valid <= 1'b1;
        r_resp_error <= 1'b1;
      end else if ((w_acc_ok && !w_cross) || w_split) begin
        r_resp_valid <= 1'b1;
        r_resp_rdata <= w_write ? 32'h0 : f_extend(w_raw_full, w_size, w_signed);
      end
      if (w_beat && w_write) begin
        r_dbg_valid <= 1'b1;
        r_dbg_addr  <= 32'({w_widx, 2'b00});
        r_dbg_word  <= w_merged;
      end
    end
  end

  assign resp_valid    = r_resp_valid;
  assign resp_rdata    = r_resp_rdata;
  assign resp_error    = r_resp_error;
  assign debug_valid   = r_dbg_valid;
  assign debug_address = r_dbg_addr;
  assign debug_word    = r_dbg_word;
  assign clear_done    = r_clear_done;

endmodule

// File: tb/tb_dm_handshake.sv
// Bench for dm_handshake: vector table driven through a response/debug scoreboard, plus
// hand-written sequences for the sweep, the non-misaligned variant and reset during a split.
module tb_dm_handshake;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_size;
  logic        req_signed;
  logic [31:0] req_address;
  logic [31:0] req_wdata;

  logic        req_ready, resp_valid, resp_error, debug_valid, clear_done;
  logic [31:0] resp_rdata, debug_address, debug_word;

  logic        na_req_ready, na_resp_valid, na_resp_error, na_debug_valid, na_clear_done;
  logic [31:0] na_resp_rdata, na_debug_address, na_debug_word;

  dm_handshake #(.ADDRESS_WIDTH(10), .ALLOW_MISALIGNED(1'b1)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_address(req_address), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_error(resp_error), .debug_valid(debug_valid),
    .debug_address(debug_address), .debug_word(debug_word), .clear_done(clear_done)
  );

  dm_handshake #(.ADDRESS_WIDTH(10), .ALLOW_MISALIGNED(1'b0)) u_dut_na (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(na_req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_address(req_address), .req_wdata(req_wdata), .resp_valid(na_resp_valid),
    .resp_rdata(na_resp_rdata), .resp_error(na_resp_error), .debug_valid(na_debug_valid),
    .debug_address(na_debug_address), .debug_word(na_debug_word),
    .clear_done(na_clear_done)
  );

  typedef struct {
    logic        wr;
    logic [2:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          ndbg;
    logic [31:0] da0, dw0, da1, dw1;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } resp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] w;
    int          due;
  } dbg_t;

  resp_t resp_q[$];
  dbg_t  dbg_q[$];
  vec_t  vecs[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int na_err_cnt = 0;
  int na_dbg_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [2:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input logic err, input int lat,
                              input int ndbg, input logic [31:0] da0, input logic [31:0] dw0,
                              input logic [31:0] da1, input logic [31:0] dw1);
    vec_t v;
    v.wr = wr; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.err = err; v.lat = lat; v.ndbg = ndbg;
    v.da0 = da0; v.dw0 = dw0; v.da1 = da1; v.dw1 = dw1;
    return v;
  endfunction

  // Scoreboard: pop on every response/debug pulse, flag stale entries as missing.
  always @(negedge clk) begin
    if (reset) begin
      if (resp_q.size() > 0 && resp_q[0].due < cyc) begin
        check("resp_missing", 32'(resp_q[0].due), 32'(cyc));
        void'(resp_q.pop_front());
      end
      if (resp_valid) begin
        if (resp_q.size() == 0) begin
          check("resp_unexpected", {31'b0, resp_valid}, 32'h0);
        end else begin
          resp_t r;
          r = resp_q.pop_front();
          check("resp_rdata", resp_rdata, r.rdata);
          check("resp_error", {31'b0, resp_error}, {31'b0, r.err});
          check("resp_cycle", 32'(cyc), 32'(r.due));
        end
      end
      if (dbg_q.size() > 0 && dbg_q[0].due < cyc) begin
        check("dbg_missing", 32'(dbg_q[0].due), 32'(cyc));
        void'(dbg_q.pop_front());
      end
      if (debug_valid) begin
        if (dbg_q.size() == 0) begin
          check("dbg_unexpected", {31'b0, debug_valid}, 32'h0);
        end else begin
          dbg_t d;
          d = dbg_q.pop_front();
          check("dbg_address", debug_address, d.a);
          check("dbg_word", debug_word, d.w);
          check("dbg_cycle", 32'(cyc), 32'(d.due));
        end
      end
    end
  end

  // Event counters for the ALLOW_MISALIGNED=0 instance.
  always @(negedge clk) begin
    if (reset && na_resp_valid && na_resp_error && na_resp_rdata == 32'h0) na_err_cnt <= na_err_cnt + 1;
    if (reset && na_debug_valid) na_dbg_cnt <= na_dbg_cnt + 1;
  end

  task automatic drive_idle();
    req_valid = 1'b0; req_write = 1'b0; req_size = 3'd0; req_signed = 1'b0;
    req_address = 32'h0; req_wdata = 32'h0;
  endtask

  task automatic do_req(input vec_t v);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("ready_timeout", {31'b0, req_ready}, 32'h1);
      return;
    end
    req_valid = 1'b1; req_write = v.wr; req_size = v.size; req_signed = v.sgn;
    req_address = v.addr; req_wdata = v.wdata;
    resp_q.push_back('{rdata: v.rdata, err: v.err, due: cyc + v.lat});
    if (v.ndbg > 0) dbg_q.push_back('{a: v.da0, w: v.dw0, due: cyc + 1});
    if (v.ndbg > 1) dbg_q.push_back('{a: v.da1, w: v.dw1, due: cyc + 2});
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic check_clear();
    int n;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("clear_ready_low", {31'b0, req_ready}, 32'h0);
    check("clear_done_low", {31'b0, clear_done}, 32'h0);
    n = 1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (req_ready) break;
      n++;
    end
    check("clear_cycles", 32'(n), 32'd256);
    check("clear_done_high", {31'b0, clear_done}, 32'h1);
  endtask

  initial begin
    int na_e0, na_d0;
    reset = 1'b0;
    drive_idle();
    #23;
    check("rst_ready", {31'b0, req_ready}, 32'h0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("rst_debug_valid", {31'b0, debug_valid}, 32'h0);
    check("rst_clear_done", {31'b0, clear_done}, 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_debug_word", debug_word, 32'h0);

    check_clear();

    //                wr    sz  sg   addr          wdata         rdata         err lat nd da0 dw0 da1 dw1
    vecs.push_back(mk(1'b0, 4, 1'b0, 32'h3FC,      32'h0,        32'h0,        0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1'b1, 4, 1'b0, 32'h10,       32'h11223344, 32'h0,        0, 1, 1,
                      32'h10, 32'h11223344, 0, 0));
    vecs.push_back(mk(1'b0, 4, 1'b0, 32'h10,       32'h0,        32'h11223344, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1'b1, 1, 1'b0, 32'h13,       32'hFFFFFF80, 32'h0,        0, 1, 1,
                      32'h10, 32'h80223344, 0, 0));
    vecs.push_back(mk(1'b0, 1, 1'b1, 32'h13,       32'h0,        32'hFFFFFF80, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1'b0, 1, 1'b0, 32'h13,       32'h0,        32'h00000080, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1'b1, 4, 1'b0, 32'h0E,       32'hAABBCCDD, 32'h0,        0, 2, 2,
                      32'h0C, 32'hCCDD0000, 32'h10, 32'h8022AABB));
    vecs.push_back(mk(1'b0, 4, 1'b0, 32'h0E,       32'h0,        32'hAABBCCDD, 0, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1'b1, 2, 1'b0, 32'h3FF,      32'h1234BEEF, 32'h0,        0, 2, 2,
                      32'h3FC, 32'hEF000000, 32'h0, 32'h000000BE));
    vecs.push_back(mk(1'b0, 2, 1'b0, 32'h3FF,      32'h0,        32'h0000BEEF, 0, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1'b0, 2, 1'b1, 32'h3FF,      32'h0,        32'hFFFFBEEF, 0, 2, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1'b0, 3, 1'b0, 32'h10,       32'h0,        32'h0,        1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1'b1, 0, 1'b0, 32'h20,       32'hFFFFFFFF, 32'h0,        1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1'b0, 5, 1'b0, 32'h10,       32'h0,        32'h0,        1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1'b0, 4, 1'b0, 32'hFFFFFC10, 32'h0,        32'h8022AABB, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1'b0, 2, 1'b1, 32'h12,       32'h0,        32'hFFFF8022, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1'b0, 1, 1'b1, 32'h12,       32'h0,        32'h00000022, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1'b0, 1, 1'b0, 32'h0F,       32'h0,        32'h000000CC, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1'b1, 2, 1'b0, 32'h21,       32'hAAAA7FFF, 32'h0,        0, 1, 1,
                      32'h20, 32'h007FFF00, 0, 0));
    vecs.push_back(mk(1'b0, 2, 1'b1, 32'h21,       32'h0,        32'h00007FFF, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1'b0, 4, 1'b1, 32'h21,       32'h0,        32'h00007FFF, 0, 2, 0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) do_req(vecs[i]);
    repeat (4) @(negedge clk);

    // Crossing store and load: the non-misaligned instance must error and never write.
    na_e0 = na_err_cnt;
    na_d0 = na_dbg_cnt;
    do_req(mk(1'b1, 4, 1'b0, 32'h2E, 32'h12345678, 32'h0, 0, 2, 2,
              32'h2C, 32'h56780000, 32'h30, 32'h00001234));
    do_req(mk(1'b0, 4, 1'b0, 32'h2E, 32'h0, 32'h12345678, 0, 2, 0, 0, 0, 0, 0));
    repeat (4) @(negedge clk);
    check("na_error_count", 32'(na_err_cnt - na_e0), 32'd2);
    check("na_debug_count", 32'(na_dbg_cnt - na_d0), 32'd0);
    check("queues_drained", 32'(resp_q.size() + dbg_q.size()), 32'd0);

    // Reset during the second beat of a crossing store: no response, sweep restarts.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 3'd4; req_signed = 1'b0;
    req_address = 32'h3E; req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("split_rst_resp", {31'b0, resp_valid}, 32'h0);
      check("split_rst_dbg", {31'b0, debug_valid}, 32'h0);
    end
    check("split_rst_done", {31'b0, clear_done}, 32'h0);
    check_clear();
    do_req(mk(1'b0, 4, 1'b0, 32'h3E,  32'h0, 32'h0, 0, 2, 0, 0, 0, 0, 0));
    do_req(mk(1'b0, 4, 1'b0, 32'h10,  32'h0, 32'h0, 0, 1, 0, 0, 0, 0, 0));
    do_req(mk(1'b0, 4, 1'b0, 32'h0E,  32'h0, 32'h0, 0, 2, 0, 0, 0, 0, 0));
    do_req(mk(1'b0, 2, 1'b0, 32'h3FF, 32'h0, 32'h0, 0, 2, 0, 0, 0, 0, 0));
    repeat (4) @(negedge clk);
    check("final_drained", 32'(resp_q.size() + dbg_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
